// File: rtl/regfile_scoreboard.sv
// Dual-write, triple-read register file with a per-register busy scoreboard.
// Optional same-cycle write-to-read bypass is enabled by defining RF_BYPASS_EN.
module regfile_scoreboard #(
    parameter int RF_WIDTH   = 3,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [RF_WIDTH-1:0]   readAddr1,
    input  logic [RF_WIDTH-1:0]   readAddr2,
    input  logic [RF_WIDTH-1:0]   readAddr3,
    output logic [DATA_WIDTH-1:0] readData1,
    output logic [DATA_WIDTH-1:0] readData2,
    output logic [DATA_WIDTH-1:0] readData3,
    output logic                  readBusy1,
    output logic                  readBusy2,
    output logic                  readBusy3,
    input  logic                  writeEn1,
    input  logic [RF_WIDTH-1:0]   writeAddr1,
    input  logic [DATA_WIDTH-1:0] writeData1,
    input  logic                  writeEn2,
    input  logic [RF_WIDTH-1:0]   writeAddr2,
    input  logic [DATA_WIDTH-1:0] writeData2,
    input  logic                  issueEn,
    input  logic [RF_WIDTH-1:0]   issueAddr,
    output logic [RF_WIDTH:0]     busyCount,
    output logic                  writeCollision
);

    localparam int NREG = 2 ** RF_WIDTH;
    localparam int CW   = RF_WIDTH + 1;

    logic [DATA_WIDTH-1:0] r_mem [NREG];
    logic [NREG-1:0]       r_busy;
    logic [CW-1:0]         r_busy_count;
    logic                  r_write_collision;

    logic                  w_we1;
    logic                  w_we2;
    logic                  w_iss;
    logic                  w_coll;
    logic [DATA_WIDTH-1:0] w_mem_nxt [NREG];
    logic [NREG-1:0]       w_busy_nxt;
    logic [RF_WIDTH-1:0]   w_raddr [3];
    logic [DATA_WIDTH-1:0] w_rdata [3];
    logic                  w_rbusy [3];

    function automatic logic [CW-1:0] popcount(input logic [NREG-1:0] v);
        logic [CW-1:0] c;
        c = {CW{1'b0}};
        for (int i = 0; i < NREG; i++) begin
            c = c + {{(CW-1){1'b0}}, v[i]};
        end
        return c;
    endfunction

    // Register 0 never takes a write or an issue, so qualify everything by a non-zero address.
    assign w_we1  = writeEn1 && (writeAddr1 != {RF_WIDTH{1'b0}});
    assign w_we2  = writeEn2 && (writeAddr2 != {RF_WIDTH{1'b0}});
    assign w_iss  = issueEn  && (issueAddr  != {RF_WIDTH{1'b0}});
    assign w_coll = w_we1 && w_we2 && (writeAddr1 == writeAddr2);

    assign w_raddr[0] = readAddr1;
    assign w_raddr[1] = readAddr2;
    assign w_raddr[2] = readAddr3;

    // Next-state of storage and scoreboard: port 1 beats port 2, issue beats writeback.
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            w_mem_nxt[i]  = r_mem[i];
            w_busy_nxt[i] = r_busy[i];
            if (i == 0) begin
                w_mem_nxt[i]  = {DATA_WIDTH{1'b0}};
                w_busy_nxt[i] = 1'b0;
            end else begin
                if (w_we1 && (writeAddr1 == RF_WIDTH'(i))) begin
                    w_mem_nxt[i] = writeData1;
                end else if (w_we2 && (writeAddr2 == RF_WIDTH'(i))) begin
                    w_mem_nxt[i] = writeData2;
                end else begin
                    w_mem_nxt[i] = r_mem[i];
                end
                if (w_iss && (issueAddr == RF_WIDTH'(i))) begin
                    w_busy_nxt[i] = 1'b1;
                end else if ((w_we1 && (writeAddr1 == RF_WIDTH'(i))) ||
                             (w_we2 && (writeAddr2 == RF_WIDTH'(i)))) begin
                    w_busy_nxt[i] = 1'b0;
                end else begin
                    w_busy_nxt[i] = r_busy[i];
                end
            end
        end
    end

    // Storage, scoreboard, busy population count and collision flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) begin
                r_mem[i] <= {DATA_WIDTH{1'b0}};
            end
            r_busy            <= {NREG{1'b0}};
            r_busy_count      <= {CW{1'b0}};
            r_write_collision <= 1'b0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                r_mem[i] <= w_mem_nxt[i];
            end
            r_busy            <= w_busy_nxt;
            r_busy_count      <= popcount(w_busy_nxt);
            r_write_collision <= w_coll;
        end
    end

    // Read muxes; the bypass forwards writeback data and hides the busy bit it is about to clear.
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            w_rdata[k] = r_mem[w_raddr[k]];
            w_rbusy[k] = r_busy[w_raddr[k]];
`ifdef RF_BYPASS_EN
            if (w_we1 && (writeAddr1 == w_raddr[k])) begin
                w_rdata[k] = writeData1;
                w_rbusy[k] = w_iss && (issueAddr == w_raddr[k]);
            end else if (w_we2 && (writeAddr2 == w_raddr[k])) begin
                w_rdata[k] = writeData2;
                w_rbusy[k] = w_iss && (issueAddr == w_raddr[k]);
            end else begin
                w_rdata[k] = r_mem[w_raddr[k]];
                w_rbusy[k] = r_busy[w_raddr[k]];
            end
`endif
            if (w_raddr[k] == {RF_WIDTH{1'b0}}) begin
                w_rdata[k] = {DATA_WIDTH{1'b0}};
                w_rbusy[k] = 1'b0;
            end else begin
                w_rdata[k] = w_rdata[k];
                w_rbusy[k] = w_rbusy[k];
            end
        end
    end

    assign readData1      = w_rdata[0];
    assign readData2      = w_rdata[1];
    assign readData3      = w_rdata[2];
    assign readBusy1      = w_rbusy[0];
    assign readBusy2      = w_rbusy[1];
    assign readBusy3      = w_rbusy[2];
    assign busyCount      = r_busy_count;
    assign writeCollision = r_write_collision;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard; expectations follow RF_BYPASS_EN when defined.
module tb_regfile_scoreboard;

    logic        clk;
    logic        reset;
    logic [2:0]  readAddr1, readAddr2, readAddr3;
    logic [15:0] readData1, readData2, readData3;
    logic        readBusy1, readBusy2, readBusy3;
    logic        writeEn1, writeEn2, issueEn;
    logic [2:0]  writeAddr1, writeAddr2, issueAddr;
    logic [15:0] writeData1, writeData2;
    logic [3:0]  busyCount;
    logic        writeCollision;

    int n_checks = 0;
    int n_fail   = 0;

    regfile_scoreboard #(.RF_WIDTH(3), .DATA_WIDTH(16)) dut (
        .clk(clk), .reset(reset),
        .readAddr1(readAddr1), .readAddr2(readAddr2), .readAddr3(readAddr3),
        .readData1(readData1), .readData2(readData2), .readData3(readData3),
        .readBusy1(readBusy1), .readBusy2(readBusy2), .readBusy3(readBusy3),
        .writeEn1(writeEn1), .writeAddr1(writeAddr1), .writeData1(writeData1),
        .writeEn2(writeEn2), .writeAddr2(writeAddr2), .writeData2(writeData2),
        .issueEn(issueEn), .issueAddr(issueAddr),
        .busyCount(busyCount), .writeCollision(writeCollision)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        writeEn1 = 1'b0; writeAddr1 = 3'd0; writeData1 = 16'h0000;
        writeEn2 = 1'b0; writeAddr2 = 3'd0; writeData2 = 16'h0000;
        issueEn  = 1'b0; issueAddr  = 3'd0;
    endtask

    task automatic wr1(input logic [2:0] a, input logic [15:0] d);
        writeEn1 = 1'b1; writeAddr1 = a; writeData1 = d;
    endtask

    task automatic wr2(input logic [2:0] a, input logic [15:0] d);
        writeEn2 = 1'b1; writeAddr2 = a; writeData2 = d;
    endtask

    task automatic iss(input logic [2:0] a);
        issueEn = 1'b1; issueAddr = a;
    endtask

    initial begin
        reset = 1'b0;
        readAddr1 = 3'd0; readAddr2 = 3'd0; readAddr3 = 3'd0;
        idle();
        #2;
        chk("reset_count", 32'(busyCount), 32'd0);
        chk("reset_coll", 32'(writeCollision), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // r3 written and issued together: data lands, issue wins the busy bit
        tick();
        wr1(3'd3, 16'hBEEF); iss(3'd3);
        tick();
        idle(); readAddr1 = 3'd3;
        #1;
        chk("r3_written", 32'(readData1), 32'h0000BEEF);
        chk("r3_busy", 32'(readBusy1), 32'd1);
        chk("count_r3", 32'(busyCount), 32'd1);
        // asynchronous reset mid-cycle, with a write in flight
        reset = 1'b0;
        wr1(3'd3, 16'h4444);
        #1;
        chk("rst_r3_data", 32'(readData1), 32'd0);
        chk("rst_r3_busy", 32'(readBusy1), 32'd0);
        chk("rst_count", 32'(busyCount), 32'd0);
        tick();
        chk("rst_inflight", 32'(readData1), 32'd0);
        idle();
        @(negedge clk);
        reset = 1'b1;

        // register 0 ignores writes and issues
        tick();
        wr1(3'd0, 16'h1234); wr2(3'd0, 16'h5678); iss(3'd0); readAddr1 = 3'd0;
        #1;
        chk("r0_same_cycle", 32'(readData1), 32'd0);
        tick();
        idle();
        #1;
        chk("r0_data", 32'(readData1), 32'd0);
        chk("r0_busy", 32'(readBusy1), 32'd0);
        chk("r0_count", 32'(busyCount), 32'd0);
        chk("r0_coll", 32'(writeCollision), 32'd0);

        // dual-write collision on r5
        wr1(3'd5, 16'h1111); wr2(3'd5, 16'h2222);
        tick();
        idle(); readAddr1 = 3'd5;
        #1;
        chk("coll_data", 32'(readData1), 32'h00001111);
        chk("coll_pulse", 32'(writeCollision), 32'd1);
        tick();
        chk("coll_clear", 32'(writeCollision), 32'd0);

        // scoreboard fill r2, r4, r6
        iss(3'd2);
        tick();
        chk("count_1", 32'(busyCount), 32'd1);
        iss(3'd4);
        tick();
        chk("count_2", 32'(busyCount), 32'd2);
        iss(3'd6); readAddr3 = 3'd6;
        #1;
        chk("issue_not_bypassed", 32'(readBusy3), 32'd0);
        tick();
        chk("count_3", 32'(busyCount), 32'd3);
        chk("r6_busy", 32'(readBusy3), 32'd1);
        idle(); readAddr1 = 3'd4;
        #1;
        chk("r4_busy", 32'(readBusy1), 32'd1);

        // two writebacks in one cycle
        wr1(3'd2, 16'h0202); wr2(3'd4, 16'h0404);
        tick();
        idle(); readAddr1 = 3'd2; readAddr2 = 3'd4;
        #1;
        chk("wb2_count", 32'(busyCount), 32'd1);
        chk("wb2_nocoll", 32'(writeCollision), 32'd0);
        chk("wb2_r2", 32'(readData1), 32'h00000202);
        chk("wb2_r4", 32'(readData2), 32'h00000404);
        chk("wb2_r4_busy", 32'(readBusy2), 32'd0);

        // issue versus write on an already-busy r7
        iss(3'd7);
        tick();
        chk("r7_count", 32'(busyCount), 32'd2);
        iss(3'd7); wr1(3'd7, 16'h00AA);
        tick();
        idle(); readAddr1 = 3'd7;
        #1;
        chk("iw_data", 32'(readData1), 32'h000000AA);
        chk("iw_busy", 32'(readBusy1), 32'd1);
        chk("iw_count", 32'(busyCount), 32'd2);

        // bypass: r1 old value 0x0101 and busy, port 2 writes 0x5A5A
        wr1(3'd1, 16'h0101);
        tick();
        idle(); iss(3'd1);
        tick();
        chk("r1_count", 32'(busyCount), 32'd3);
        idle(); wr2(3'd1, 16'h5A5A); readAddr2 = 3'd1;
        #1;
`ifdef RF_BYPASS_EN
        chk("byp_data", 32'(readData2), 32'h00005A5A);
        chk("byp_busy", 32'(readBusy2), 32'd0);
`else
        chk("nobyp_data", 32'(readData2), 32'h00000101);
        chk("nobyp_busy", 32'(readBusy2), 32'd1);
`endif
        tick();
        idle();
        #1;
        chk("r1_after_data", 32'(readData2), 32'h00005A5A);
        chk("r1_after_busy", 32'(readBusy2), 32'd0);
        chk("r1_after_count", 32'(busyCount), 32'd2);

        // saturation: issue r1..r7
        for (int a = 1; a < 8; a++) begin
            iss(3'(a));
            tick();
        end
        chk("sat_count", 32'(busyCount), 32'd7);
        idle(); iss(3'd3); wr1(3'd3, 16'h3333); readAddr3 = 3'd3;
        #1;
`ifdef RF_BYPASS_EN
        chk("iw_byp_data", 32'(readData3), 32'h00003333);
`else
        chk("iw_nobyp_data", 32'(readData3), 32'h00000000);
`endif
        chk("iw_same_busy", 32'(readBusy3), 32'd1);
        tick();
        idle();
        #1;
        chk("sat_hold", 32'(busyCount), 32'd7);
        chk("sat_r3_data", 32'(readData3), 32'h00003333);
        chk("sat_r3_busy", 32'(readBusy3), 32'd1);
        wr1(3'd1, 16'h0001); wr2(3'd2, 16'h0002);
        tick();
        idle();
        chk("dec_by_2", 32'(busyCount), 32'd5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Parametrised dual-write, triple-read register file with a per-register busy scoreboard, for the decode/writeback boundary of the pipelined MIPS datapath. Two writeback ports cover the ALU result path and the load-return path. An issue port marks destination registers as pending, and writeback clears them. Optional same-cycle write-to-read bypass removes the extra cycle between writeback and decode.

## Interface
- RF_WIDTH, 3, address width; the file holds 2**RF_WIDTH registers.
- DATA_WIDTH, 16, register data width.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- readAddr1/2/3  input  RF_WIDTH  read port addresses.
- readData1/2/3  output  DATA_WIDTH  read data, combinational.
- readBusy1/2/3  output  1  scoreboard state of the addressed register, combinational.
- writeEn1  input  1  write port 1 enable; ALU path; highest priority.
- writeAddr1  input  RF_WIDTH  write port 1 address.
- writeData1  input  DATA_WIDTH  write port 1 data.
- writeEn2/writeAddr2/writeData2  input  1/RF_WIDTH/DATA_WIDTH  write port 2; load path.
- issueEn  input  1  marks issueAddr as having an outstanding producer.
- issueAddr  input  RF_WIDTH  destination being issued.
- busyCount  output  RF_WIDTH+1  registered count of busy registers.
- writeCollision  output  1  registered one-cycle pulse: both ports wrote the same non-zero address in the previous cycle.

## Operation
- Register 0 is hardwired to zero.
  - Writes to it are dropped.
  - An issue to it is ignored; its busy bit is always 0.
  - A read of it returns 0 and readBusy = 0 in every configuration.
- Writes:
  - An enabled port with a non-zero address writes its data on the rising clock edge.
  - When both ports target the same address, port 1 data is stored and port 2 is discarded.
  - In that case writeCollision = 1 in the following cycle only.
- Scoreboard: busy[a] next state, evaluated per address:
  - issue hit on a → 1. Issue wins over a same-cycle write, because a new producer supersedes the old one.
  - otherwise, a write hit on a from either port → 0.
  - otherwise → hold.
- Writes to a non-busy register are legal and leave busy at 0.
- busyCount always equals the population count of busy[] after each clock edge.
  - Each cycle it changes by at most +1 (one issue) and at most −2 (two writebacks).
  - Its maximum is 2**RF_WIDTH−1.
- Reads:
  - readData is mem[readAddr], subject to the bypass rule in Configuration.
  - readBusy is busy[readAddr], subject to the same rule.

## Timing
- Reset, asserted (reset = 0):
  - Immediately, without waiting for a clock edge, all registers, busy bits, busyCount and writeCollision go to 0.
  - Outputs then read readData = 0 and readBusy = 0 for every address.
- Reset asserted mid-operation discards in-flight writes and issues in the same cycle.
- Reset deassertion is synchronised externally; the first edge after release is a normal cycle.
- Write latency: data is visible on the non-bypassed read path one cycle after the write edge.
- Issue latency: readBusy rises on the cycle after issueEn is sampled; it is never bypassed.
- busyCount and writeCollision are registered and update on the same edge as busy[] and mem.

## Configuration
- Macro RF_BYPASS_EN.
- Defined:
  - A read whose address matches an enabled, non-zero same-cycle write returns that write's data. Port 1 is used when both ports match.
  - readBusy is forced to 0 for that read unless the same address is also being issued this cycle.
- Undefined:
  - Reads return the stored pre-edge value and the stored busy bit.
  - The consumer stalls one extra cycle.

## Test plan
- Reset and register 0:
  - Stimulus: write 0xBEEF to r3, then pulse reset low mid-cycle.
  - Required: readData for r3 is 0 immediately and busyCount = 0.
  - Stimulus: write 0x1234 to r0.
  - Required: readData1(r0) = 0.
- Dual-write collision:
  - Stimulus: in one cycle, port 1 writes r5 = 0x1111 and port 2 writes r5 = 0x2222.
  - Required: r5 = 0x1111 next cycle, writeCollision = 1 for exactly one cycle.
- Scoreboard:
  - Stimulus: issue r2, r4, r6 on consecutive cycles.
  - Required: busyCount goes 1, 2, 3 and readBusy(r4) = 1.
  - Stimulus: same-cycle writebacks to r2 (port 1) and r4 (port 2).
  - Required: busyCount = 1.
- Issue versus write:
  - Stimulus: in one cycle, issue r7 and port 1 writes r7 = 0x00AA.
  - Required: r7 = 0x00AA, busy[r7] = 1, busyCount unchanged from a state where r7 was already busy.
- Bypass (RF_BYPASS_EN defined):
  - Stimulus: port 2 writes r1 = 0x5A5A while readAddr2 = 1 and r1 is busy.
  - Required: readData2 = 0x5A5A and readBusy2 = 0 in the same cycle.
- Bypass (RF_BYPASS_EN undefined):
  - Stimulus: the same write and read.
  - Required: the read returns the old value and readBusy2 = 1 in the same cycle.
- Saturation:
  - Stimulus: issue all of r1..r7 (RF_WIDTH = 3).
  - Required: busyCount = 7; a further issue to r3 leaves it at 7.
